io_bus_responder: RTL

IO_BUS_RESPONDER -- requirements
Module: io_bus_responder

---
 rtl/io_map_pkg.sv | 20 ++
 rtl/button_debounce.sv | 49 ++++
 rtl/io_bus_responder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/io_map_pkg.sv
// Shared address map for the processor-side MMIO page: page select, register
// offsets and the STATUS register layout.
package io_map_pkg;

  localparam logic [7:0] MMIO_PAGE    = 8'hFF;
  localparam logic [3:0] OFS_STATUS   = 4'h0;
  localparam logic [3:0] OFS_FRAMECNT = 4'h1;
  localparam logic [3:0] OFS_SCORE    = 4'h2;
  localparam logic [3:0] OFS_PERIOD   = 4'h3;

  typedef struct packed {
    logic level;
    logic sticky;
  } status_t;

  function automatic logic is_mmio(input logic [11:0] addr);
    return addr[11:4] == MMIO_PAGE;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a stability-counter debouncer. rise pulses
// in the same cycle the debounced level is about to go 0->1.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic button_async,
  output logic level,
  output logic rise
);

  localparam int SYNC_STAGES = 2;
  localparam int CW          = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   level_reg;
  logic [CW-1:0]          cnt_reg;
  logic                   synced;
  logic                   differ;
  logic                   expire;

  assign synced = sync_reg[SYNC_STAGES-1];
  assign differ = synced != level_reg;
  // The Nth consecutive disagreeing cycle is the one that commits the new level.
  assign expire = differ && (cnt_reg == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_reg  <= '0;
      level_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], button_async};
      if (!differ) begin
        cnt_reg <= '0;
      end else if (expire) begin
        level_reg <= synced;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign level = level_reg;
  assign rise  = expire && synced;

endmodule

// File: rtl/io_bus_responder.sv
// Data-memory bus responder: splits processor accesses between RAM and a small
// MMIO page (button status, frame counter, score, frame period).
module io_bus_responder
  import io_map_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int unsigned FRAME_DEFAULT   = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wren,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic [31:0] ram_q,
  output logic        ram_wren,
  output logic [31:0] q_dmem,
  input  logic        up_button,
  output logic [15:0] score_out,
  output logic        frame_tick
);

  logic        mmio;
  logic [3:0]  ofs;
  logic        wr_mmio;
  logic        clr_sticky;
  logic        wr_score;
  logic        wr_period;
  logic        tick;
  logic        level;
  logic        rise;
  logic        unused_addr;

  logic        sticky_reg;
  logic [15:0] score_reg;
  logic [31:0] period_reg;
  logic [31:0] div_reg;
  logic [31:0] framecnt_reg;
  logic        sel_reg;
  logic [31:0] rdata_reg;
  logic [31:0] rdata_next;
  status_t     status;

  assign unused_addr = ^address_dmem[31:12];

  assign mmio       = is_mmio(address_dmem[11:0]);
  assign ofs        = address_dmem[3:0];
  assign wr_mmio    = wren && mmio;
  assign clr_sticky = wr_mmio && (ofs == OFS_STATUS) && data[0];
  assign wr_score   = wr_mmio && (ofs == OFS_SCORE);
  assign wr_period  = wr_mmio && (ofs == OFS_PERIOD);
  assign ram_wren   = wren && !mmio;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock       (clock),
    .reset       (reset),
    .button_async(up_button),
    .level       (level),
    .rise        (rise)
  );

  // A zero period parks the divider at 0, so the compare below never matches.
  assign tick       = (period_reg != 32'd0) && (div_reg == period_reg - 32'd1);
  assign frame_tick = tick;

  always_ff @(posedge clock) begin
    if (reset) begin
      div_reg      <= '0;
      framecnt_reg <= '0;
      period_reg   <= 32'(FRAME_DEFAULT);
    end else begin
      if (wr_period) begin
        period_reg <= data;
      end
      if (tick) begin
        framecnt_reg <= framecnt_reg + 32'd1;
      end
      if (wr_period || tick || (period_reg == 32'd0)) begin
        div_reg <= '0;
      end else begin
        div_reg <= div_reg + 32'd1;
      end
    end
  end

  // A press edge takes priority over a software clear in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      sticky_reg <= 1'b0;
      score_reg  <= '0;
    end else begin
      if (rise) begin
        sticky_reg <= 1'b1;
      end else if (clr_sticky) begin
        sticky_reg <= 1'b0;
      end
      if (wr_score) begin
        score_reg <= data[15:0];
      end
    end
  end

  assign status = '{level: level, sticky: sticky_reg};

  always_comb begin
    rdata_next = '0;
    case (ofs)
      OFS_STATUS:   rdata_next = {30'd0, status};
      OFS_FRAMECNT: rdata_next = framecnt_reg;
      OFS_SCORE:    rdata_next = {16'd0, score_reg};
      OFS_PERIOD:   rdata_next = period_reg;
      default:      rdata_next = '0;
    endcase
  end

  // Registering the read keeps MMIO latency equal to the RAM's one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      sel_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      sel_reg   <= mmio;
      rdata_reg <= rdata_next;
    end
  end

  assign q_dmem    = sel_reg ? rdata_reg : ram_q;
  assign score_out = score_reg;

endmodule
